// File: rtl/cv32e40x_tb_obi_mem.sv
// OBI memory responder for the core testbench.
// Supports a bounded number of outstanding transactions, grant stalls,
// fixed response latency and an address window that answers with errors.
module cv32e40x_tb_obi_mem #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned RAM_ADDR_WIDTH   = 16,
    parameter int unsigned MAX_OUTSTANDING  = 2,
    parameter int unsigned GNT_STALL_MODE   = 0,
    parameter int unsigned GNT_STALL_CYCLES = 2,
    parameter int unsigned RVALID_LATENCY   = 1,
    parameter logic [31:0] LFSR_SEED        = 32'hACE1_0001,
    parameter logic [31:0] ERR_BASE         = 32'h0,
    parameter logic [31:0] ERR_MASK         = 32'h0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [31:0]             addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic [3:0]              outstanding_o
);
    localparam int unsigned BE_W      = DATA_WIDTH / 8;
    localparam int unsigned BE_AW     = $clog2(BE_W);
    localparam int unsigned WORD_AW   = RAM_ADDR_WIDTH - BE_AW;
    localparam int unsigned NUM_WORDS = 2 ** WORD_AW;
    localparam int unsigned PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned STALL_W   = (GNT_STALL_CYCLES > 0) ? $clog2(GNT_STALL_CYCLES + 1) : 1;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [3:0]  LAT_LOAD  = 4'(RVALID_LATENCY - 1);
    localparam logic [3:0]  MAX_OUT   = 4'(MAX_OUTSTANDING);

    logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [31:0]           lfsr_q, lfsr_d;
    logic [3:0]            outstanding_q, outstanding_d;
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] fifo_rdata_q [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0] fifo_rdata_d [MAX_OUTSTANDING];
    logic                  fifo_err_q   [MAX_OUTSTANDING];
    logic                  fifo_err_d   [MAX_OUTSTANDING];
    logic [3:0]            fifo_cnt_q   [MAX_OUTSTANDING];
    logic [3:0]            fifo_cnt_d   [MAX_OUTSTANDING];
    logic [DATA_WIDTH-1:0] mem_q        [NUM_WORDS];

    logic [WORD_AW-1:0] word_idx;
    logic               accept;
    logic               addr_err;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    // Upper address bits beyond the RAM size are ignored, so the RAM aliases.
    assign word_idx = addr_i[RAM_ADDR_WIDTH-1:BE_AW];
    assign addr_err = (ERR_MASK != '0) && ((addr_i & ERR_MASK) == (ERR_BASE & ERR_MASK));

    // No bypass when full: a retiring response does not free a slot in the same cycle.
    assign gnt_o  = req_i && (stall_cnt_q == '0) && (outstanding_q < MAX_OUT);
    assign accept = req_i && gnt_o;

    assign pop           = (outstanding_q != 4'd0) && (fifo_cnt_q[rptr_q] == 4'd0);
    assign rvalid_o      = pop;
    assign rdata_o       = pop ? fifo_rdata_q[rptr_q] : '0;
    assign err_o         = pop && fifo_err_q[rptr_q];
    assign outstanding_o = outstanding_q;

    // Grant stall countdown, reloaded on every accept.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            if (GNT_STALL_MODE == 1) begin
                stall_cnt_d = STALL_W'(GNT_STALL_CYCLES);
            end else if (GNT_STALL_MODE == 2) begin
                stall_cnt_d = STALL_W'(32'(lfsr_q[7:0]) % (GNT_STALL_CYCLES + 1));
            end else begin
                stall_cnt_d = '0;
            end
        end else if (stall_cnt_q != '0) begin
            stall_cnt_d = stall_cnt_q - 1'b1;
        end
    end

    // Galois LFSR, only free-running in pseudo-random stall mode.
    always_comb begin
        lfsr_d = lfsr_q;
        if (GNT_STALL_MODE == 2) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
        end
    end

    // Response FIFO: push on accept, pop when the head countdown has expired.
    always_comb begin
        fifo_rdata_d = fifo_rdata_q;
        fifo_err_d   = fifo_err_q;
        fifo_cnt_d   = fifo_cnt_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
            if (fifo_cnt_q[i] != 4'd0) begin
                fifo_cnt_d[i] = fifo_cnt_q[i] - 4'd1;
            end
        end
        if (accept) begin
            fifo_rdata_d[wptr_q] = (we_i || addr_err) ? '0 : mem_q[word_idx];
            fifo_err_d[wptr_q]   = addr_err;
            fifo_cnt_d[wptr_q]   = LAT_LOAD;
            wptr_d               = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
    end

    // Occupancy tracking; accept and response in one cycle cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !pop) begin
            outstanding_d = outstanding_q + 4'd1;
        end else if (!accept && pop) begin
            outstanding_d = outstanding_q - 4'd1;
        end
    end

    // Control and FIFO state; reset discards any pending responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q   <= '0;
            lfsr_q        <= LFSR_SEED;
            outstanding_q <= 4'd0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_rdata_q[i] <= '0;
                fifo_err_q[i]   <= 1'b0;
                fifo_cnt_q[i]   <= 4'd0;
            end
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            lfsr_q        <= lfsr_d;
            outstanding_q <= outstanding_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            fifo_rdata_q  <= fifo_rdata_d;
            fifo_err_q    <= fifo_err_d;
            fifo_cnt_q    <= fifo_cnt_d;
        end
    end

    // Byte-lane writes land at the accept edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && !addr_err) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be_i[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // A stalled request may be withdrawn, but must not change while still asserted.
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> (!req_i || ($stable(addr_i) && $stable(we_i) &&
                                          $stable(be_i) && $stable(wdata_i))))
        else $error("obi_mem: request changed while waiting for grant");

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        accept |-> (outstanding_q < MAX_OUT))
        else $error("obi_mem: response fifo overflow");

    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pop |-> (outstanding_q != 4'd0))
        else $error("obi_mem: response fifo underflow");

endmodule

// File: tb/tb_cv32e40x_tb_obi_mem.sv
// Directed bench for the OBI memory responder: three instances cover
// zero-wait with an error window, deep latency, and fixed grant stalls.
module tb_cv32e40x_tb_obi_mem;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance A: mode 0, latency 1, error window at 0x0001_xxxx.
    logic        a_req = 1'b0, a_gnt, a_we = 1'b0, a_rvalid, a_err;
    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic [3:0]  a_be = '0, a_out;
    // Instance B: latency 4, two outstanding.
    logic        b_req = 1'b0, b_gnt, b_we = 1'b0, b_rvalid, b_err;
    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic [3:0]  b_be = '0, b_out;
    // Instance C: fixed stall of three cycles.
    logic        c_req = 1'b0, c_gnt, c_we = 1'b0, c_rvalid, c_err;
    logic [31:0] c_addr = '0, c_wdata = '0, c_rdata;
    logic [3:0]  c_be = '0, c_out;

    cv32e40x_tb_obi_mem #(
        .ERR_BASE(32'h0001_0000),
        .ERR_MASK(32'hFFFF_0000)
    ) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .gnt_o(a_gnt), .addr_i(a_addr),
        .we_i(a_we), .be_i(a_be), .wdata_i(a_wdata), .rvalid_o(a_rvalid),
        .rdata_o(a_rdata), .err_o(a_err), .outstanding_o(a_out)
    );

    cv32e40x_tb_obi_mem #(
        .MAX_OUTSTANDING(2),
        .RVALID_LATENCY(4)
    ) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .gnt_o(b_gnt), .addr_i(b_addr),
        .we_i(b_we), .be_i(b_be), .wdata_i(b_wdata), .rvalid_o(b_rvalid),
        .rdata_o(b_rdata), .err_o(b_err), .outstanding_o(b_out)
    );

    cv32e40x_tb_obi_mem #(
        .GNT_STALL_MODE(1),
        .GNT_STALL_CYCLES(3)
    ) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(c_req), .gnt_o(c_gnt), .addr_i(c_addr),
        .we_i(c_we), .be_i(c_be), .wdata_i(c_wdata), .rvalid_o(c_rvalid),
        .rdata_o(c_rdata), .err_o(c_err), .outstanding_o(c_out)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Single isolated transaction on instance A with its response one cycle later.
    task automatic a_txn(input vec_t v, input string tag);
        @(posedge clk); #1;
        a_req   = 1'b1;
        a_we    = v.we;
        a_addr  = v.addr;
        a_be    = v.be;
        a_wdata = v.wdata;
        @(negedge clk);
        check({tag, " gnt"}, a_gnt, 1);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        check({tag, " rvalid"}, a_rvalid, 1);
        check({tag, " rdata"}, a_rdata, v.exp_rdata);
        check({tag, " err"}, a_err, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] exp_gnt3;
        logic [11:0] exp_rv3;
        int          exp_out3 [12];
        vec_t        rd100;

        exp_gnt3 = 12'b1100_0110_0011;
        exp_rv3  = 12'b0110_0011_0000;
        exp_out3 = '{0, 1, 2, 2, 2, 1, 1, 2, 2, 2, 1, 1};

        vecs[0]  = '{1'b1, 32'h0000_0200, 4'hF, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0200, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0200, 4'h0, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0200, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0203, 4'h8, 32'h7700_0000, 32'h0,         1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0200, 4'hF, 32'h0,         32'h77AD_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0204, 4'hF, 32'h1122_3344, 32'h0,         1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0204, 4'h5, 32'hAABB_CCDD, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0204, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[9]  = '{1'b0, 32'h0002_0204, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0004, 4'hF, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[11] = '{1'b1, 32'h0001_0004, 4'hF, 32'h0000_0005, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 32'h0000_0004, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[13] = '{1'b0, 32'h0001_FFFC, 4'hF, 32'h0,         32'h0,         1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset a_gnt", a_gnt, 0);
        check("reset a_rvalid", a_rvalid, 0);
        check("reset a_rdata", a_rdata, 0);
        check("reset a_err", a_err, 0);
        check("reset a_out", a_out, 0);
        check("reset b_out", b_out, 0);
        rst_n = 1'b1;

        // Back-to-back write then read at zero wait
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h100; a_be = 4'hF; a_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("t1 wr gnt", a_gnt, 1);
        check("t1 wr rvalid early", a_rvalid, 0);
        @(posedge clk); #1;
        a_we = 1'b0; a_wdata = '0;
        @(negedge clk);
        check("t1 rd gnt", a_gnt, 1);
        check("t1 wr rvalid", a_rvalid, 1);
        check("t1 wr rdata", a_rdata, 0);
        check("t1 wr err", a_err, 0);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        check("t1 rd rvalid", a_rvalid, 1);
        check("t1 rd rdata", a_rdata, 32'hDEAD_BEEF);
        check("t1 rd err", a_err, 0);
        @(negedge clk);
        check("t1 idle rvalid", a_rvalid, 0);
        check("t1 idle out", a_out, 0);

        // Full FIFO with latency 4: no grant until a slot has retired
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_be = 4'hF; b_wdata = 32'h1234_5678;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("t3 gnt c%0d", i), b_gnt, exp_gnt3[i]);
            check($sformatf("t3 rvalid c%0d", i), b_rvalid, exp_rv3[i]);
            check($sformatf("t3 out c%0d", i), b_out, exp_out3[i]);
        end
        @(posedge clk); #1;
        b_req = 1'b0;

        // Fixed stall of 3: grants every fourth cycle, first one immediate
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h80; c_be = 4'hF; c_wdata = 32'h0BAD_F00D;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check($sformatf("t4 gnt c%0d", i), c_gnt, (i % 4 == 0) ? 1 : 0);
            check($sformatf("t4 rvalid c%0d", i), c_rvalid, (i % 4 == 1) ? 1 : 0);
        end
        @(posedge clk); #1;
        c_req = 1'b0;

        // Table-driven byte enables, aliasing and error window
        for (int i = 0; i < 14; i++) begin
            a_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset with two responses pending on B
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h40; b_be = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_req = 1'b0;
        #2;
        check("t6 pending before reset", b_out, 2);
        rst_n = 1'b0;
        #1;
        check("t6 async b_out", b_out, 0);
        check("t6 async b_rvalid", b_rvalid, 0);
        check("t6 async b_rdata", b_rdata, 0);
        check("t6 async b_err", b_err, 0);
        check("t6 async a_rvalid", a_rvalid, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("t6 no rvalid c%0d", i), b_rvalid, 0);
        end
        check("t6 b_out after", b_out, 0);
        rd100 = '{1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0};
        a_txn(rd100, "t6 mem kept");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40x_tb_obi_mem.md
Name: cv32e40x_tb_obi_mem

Overview:
Parametrised OBI memory responder for the core testbench. It replaces the fixed zero-wait RAM behaviour with a configurable number of outstanding transactions, programmable grant stalls and response latency, and address-window error injection. One instance serves one OBI port, either instruction or data. Two instances plus the core form the next-generation TB wrapper.

Parameters:
DATA_WIDTH, 32, bus data width; multiple of 8; BE width is DATA_WIDTH/8.
RAM_ADDR_WIDTH, 16, byte-address bits decoded; memory is 2**RAM_ADDR_WIDTH bytes.
MAX_OUTSTANDING, 2, response FIFO depth, 1..8.
GNT_STALL_MODE, 0, grant stall mode: 0 none, 1 fixed, 2 pseudo-random.
GNT_STALL_CYCLES, 2, fixed stall length (mode 1), or maximum stall length (mode 2).
RVALID_LATENCY, 1, cycles from accept to rvalid_o, 1..15.
LFSR_SEED, 32'hACE1_0001, reset value of the stall LFSR; must be nonzero.
ERR_BASE, 32'h0, error window base.
ERR_MASK, 32'h0, error window mask; 0 disables error injection.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  1  OBI request
gnt_o  out  1  OBI grant
addr_i  in  32  byte address
we_i  in  1  write enable
be_i  in  DATA_WIDTH/8  byte enables
wdata_i  in  DATA_WIDTH  write data
rvalid_o  out  1  response valid, one cycle per transaction
rdata_o  out  DATA_WIDTH  read data; 0 when rvalid_o is low or for writes
err_o  out  1  response error; valid with rvalid_o
outstanding_o  out  4  transactions accepted but not yet responded

Behaviour:
- One clock domain, clk_i. rst_ni is asynchronous, active-low.
- Reset values:
  - stall_cnt=0, FIFO empty, outstanding_o=0, rvalid_o=0, rdata_o=0, err_o=0, LFSR=LFSR_SEED.
  - Memory contents are NOT reset.
- gnt_o is combinational: gnt_o = req_i && stall_cnt==0 && outstanding_o<MAX_OUTSTANDING. There is no bypass when the FIFO is full, even if a response retires that cycle.
- Accept occurs when req_i && gnt_o:
  - Word index is addr_i[RAM_ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; higher address bits are ignored (wrap).
  - Error: ERR_MASK!=0 && (addr_i & ERR_MASK)==(ERR_BASE & ERR_MASK). The write is suppressed and the entry is pushed with err=1, rdata=0.
  - Write: bytes with be set are updated at the accept edge. The entry is pushed with rdata=0, err=0.
  - Read: word data is captured at accept, reflecting all previously accepted writes. Entry is pushed with err=0.
  - Each entry carries a countdown loaded with RVALID_LATENCY-1.
- Stall counter:
  - On accept, stall_cnt loads 0 (mode 0), GNT_STALL_CYCLES (mode 1), or LFSR[7:0] % (GNT_STALL_CYCLES+1) (mode 2).
  - Otherwise it decrements while nonzero, independent of req_i.
- LFSR: 32-bit Galois, polynomial 32'h8020_0003, shifts every cycle in mode 2 only.
- Response:
  - Head-entry countdown reaches 0 -> rvalid_o=1 that cycle with the head's rdata/err, then pop.
  - Responses are strictly in order, at most one per cycle.
  - Non-head countdowns decrement every cycle, saturating at 0.
  - RVALID_LATENCY=1 means rvalid_o is asserted the cycle after accept.
- outstanding_o: +1 on accept, -1 on response; simultaneous accept and response leaves it unchanged.
- req_i dropped before grant: no state change except the stall countdown.
- Reset mid-operation: pending responses are discarded, no rvalid_o is emitted after deassertion, and the stall state is reseeded.
- Simulation assertions:
  - Flag addr/we/be/wdata changing while req_i && !gnt_o.
  - Flag FIFO overflow and underflow.

Test Plan:
1. Mode 0, latency 1: write 32'hDEAD_BEEF (be=4'hF) to 0x100, then read 0x100 back-to-back -> gnt_o in the same cycle as each request; rvalid_o at cycles +1 and +2; read rdata_o=32'hDEAD_BEEF.
2. Byte enables: write 32'h1122_3344 be=4'hF, then 32'hAABB_CCDD be=4'b0101, then read -> rdata_o=32'h11BB_33DD.
3. MAX_OUTSTANDING=2, RVALID_LATENCY=4, req_i held high -> two grants on consecutive cycles, gnt_o low until the first rvalid_o, outstanding_o sequence 1,2,2,2,1...
4. Mode 1, GNT_STALL_CYCLES=3, continuous requests -> grants spaced 4 cycles apart; first grant immediate after reset.
5. ERR_BASE=32'h0001_0000, ERR_MASK=32'hFFFF_0000: write 32'h5 to 0x0001_0004, then read 0x0000_0004 (aliased word) -> first response err_o=1; second response err_o=0 with the prior contents, confirming the write was suppressed.
6. Reset asserted with 2 responses pending -> all outputs 0 asynchronously, no rvalid_o after release, memory still holds the test 1 data.
